// File: rtl/bram_dp_param.sv
// rtl/bram_dp_param.sv - simple dual-port block RAM with byte enables and post-reset clear sweep
// One write port, one read port, single clock; optional output register and read-during-write bypass.
module bram_dp_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 15,
    parameter int DEPTH   = 24576,
    parameter int OUT_REG = 0,
    parameter int RDW_NEW = 0,
    parameter int CLR_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
    output logic                  wr_err,
    output logic                  ready
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0]   DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0]  LAST_IDX = DEPTH_M1[IDX_W-1:0];

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    clr_cnt;
    logic                run;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                wr_in_rng, wr_fire;
    logic                rd_in_rng, rd_fire;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DATA_W-1:0]   old_word, merged, s0_data;
    logic                byp;

    logic [DATA_W-1:0]   s1_data;
    logic                s1_valid, s1_oob;

    assign run   = (state == RUN);
    assign ready = run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLR_EN != 0) ? CLEAR : RUN;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == LAST_IDX) begin
            state_nxt = RUN;
        end
    end

    assign wr_in_rng = {1'b0, wr_addr} < DEPTH_C;
    assign rd_in_rng = {1'b0, rd_addr} < DEPTH_C;
    assign wr_fire   = run && wr_en && wr_in_rng;
    assign rd_fire   = run && rd_en;
    assign wr_idx    = wr_addr[IDX_W-1:0];
    assign rd_idx    = rd_addr[IDX_W-1:0];

    // Array has no reset so it maps onto BRAM; the sweep owns the write port while not running.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign old_word = mem[rd_idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Same-address collision: forward the merged word only when new-data semantics are chosen.
    assign byp     = (RDW_NEW != 0) && wr_fire && (wr_addr == rd_addr);
    assign s0_data = !rd_in_rng ? '0 : (byp ? merged : old_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_oob   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            s1_oob   <= rd_fire && !rd_in_rng;
            wr_err   <= run && wr_en && !wr_in_rng;
            if (rd_fire) begin
                s1_data <= s0_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                    rd_oob   <= 1'b0;
                end else begin
                    rd_valid <= s1_valid;
                    rd_oob   <= s1_oob;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_noreg
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
            assign rd_oob   = s1_oob;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_param.sv
// tb/tb_bram_dp_param.sv - scoreboard bench for bram_dp_param (DEPTH=20, OUT_REG=1, RDW_NEW=1)
module tb_bram_dp_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 20;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [1:0]        wr_be = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_oob, wr_err, ready;

    bram_dp_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .OUT_REG(1), .RDW_NEW(1), .CLR_EN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob),
        .wr_err(wr_err), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               at;
        logic [DATA_W-1:0] d;
        logic             oob;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got data %h oob %b expected no result (cycle %0d)", rd_data, rd_oob, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_cycle", cyc, e.at);
                check("rd_data", {16'h0, rd_data}, {16'h0, e.d});
                check("rd_oob", {31'h0, rd_oob}, {31'h0, e.oob});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that captured the request.
    task automatic op(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [1:0] be, input bit re, input logic [ADDR_W-1:0] ra,
                      input logic [DATA_W-1:0] ed, input bit eo);
        exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re) begin
            e.at = cyc + LAT; e.d = ed; e.oob = eo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] be);
        op(1'b1, a, d, be, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ed, input bit eo);
        op(1'b0, '0, '0, 2'b00, 1'b1, a, ed, eo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 1'b0);
    endtask

    // Counts cycles from reset release until ready; optionally pokes the ports during the sweep.
    task automatic sweep(input bit poke);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            if (poke && n < 3) begin
                wr_en = 1'b1; wr_addr = 5'd24; wr_data = 16'hFFFF; wr_be = 2'b11;
                rd_en = 1'b1; rd_addr = 5'd3;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (poke && n <= 3) check("clear_wr_err", {31'h0, wr_err}, 32'h0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("sweep_len", n, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("rst_rd_data", {16'h0, rd_data}, 32'h0);
        check("rst_wr_err", {31'h0, wr_err}, 32'h0);
        rst = 1'b0;
        sweep(1'b0);

        for (int a = 0; a < DEPTH; a++) rd(a[ADDR_W-1:0], 16'h0000, 1'b0);

        wr(5'd5, 16'hBEEF, 2'b11);
        wr(5'd5, 16'h12AA, 2'b01);
        rd(5'd5, 16'hBEAA, 1'b0);
        wr(5'd5, 16'hFFFF, 2'b00);
        rd(5'd5, 16'hBEAA, 1'b0);

        wr(5'd7, 16'h1111, 2'b11);
        op(1'b1, 5'd7, 16'h2222, 2'b11, 1'b1, 5'd7, 16'h2222, 1'b0);
        op(1'b1, 5'd7, 16'h33CC, 2'b10, 1'b1, 5'd7, 16'h3322, 1'b0);
        op(1'b1, 5'd8, 16'h4444, 2'b11, 1'b1, 5'd7, 16'h3322, 1'b0);
        rd(5'd8, 16'h4444, 1'b0);

        wr(5'd24, 16'hDEAD, 2'b11);
        check("wr_err_pulse", {31'h0, wr_err}, 32'h1);
        idle(1);
        check("wr_err_clear", {31'h0, wr_err}, 32'h0);
        wr(5'd20, 16'hDEAD, 2'b11);
        check("wr_err_boundary", {31'h0, wr_err}, 32'h1);
        rd(5'd4, 16'h0000, 1'b0);
        rd(5'd8, 16'h4444, 1'b0);
        rd(5'd24, 16'h0000, 1'b1);
        rd(5'd31, 16'h0000, 1'b1);
        rd(5'd19, 16'h0000, 1'b0);

        wr(5'd0, 16'hA5A5, 2'b11);
        wr(5'd1, 16'hB6B6, 2'b11);
        wr(5'd2, 16'hC7C7, 2'b11);
        wr(5'd3, 16'hD8D8, 2'b11);
        rd(5'd0, 16'hA5A5, 1'b0);
        rd(5'd1, 16'hB6B6, 1'b0);
        rd(5'd2, 16'hC7C7, 1'b0);
        rd(5'd3, 16'hD8D8, 1'b0);
        idle(3);
        check("rd_data_hold", {16'h0, rd_data}, 32'h0000D8D8);
        check("rd_valid_idle", {31'h0, rd_valid}, 32'h0);
        check("queue_drained", exp_q.size(), 0);

        rd_en = 1'b1; rd_addr = 5'd2;
        @(posedge clk); #1;
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midread_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("midread_rd_data", {16'h0, rd_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_again", {31'h0, ready}, 32'h0);
        rst = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("midsweep_ready", {31'h0, ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep(1'b1);

        rd(5'd3, 16'h0000, 1'b0);
        rd(5'd5, 16'h0000, 1'b0);
        idle(4);
        check("queue_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
